// File: rtl/led_pattern_master.sv
// rtl/led_pattern_master.sv - LED pattern sequencer that writes each pattern to an Avalon-MM slave and verifies it by readback
module led_pattern_master #(
    parameter int TICK_DIV     = 50000000,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        clear_error,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [9:0]  pattern,
    output logic        busy,
    output logic        error,
    output logic [7:0]  mismatch_count
);

    localparam int              CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   TICK_MAX = CW'(TICK_DIV - 1);
    localparam logic [2:0]      LAT_MAX  = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RDWAIT,
        S_CHECK
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_tick_cnt;
    logic [9:0]    r_pattern;
    logic          r_cs;
    logic          r_we;
    logic          r_rd;
    logic [31:0]   r_wdata;
    logic [2:0]    r_lat;
    logic [31:0]   r_rdata;
    logic          r_error;
    logic [7:0]    r_cnt;

    logic          w_tick;
    logic [9:0]    w_next_pattern;
    logic          w_mismatch;
    logic [7:0]    w_cnt_base;
    logic [7:0]    w_cnt_inc;

    assign w_tick = enable && (r_tick_cnt == TICK_MAX);

    // Free-running tick divider; parked at zero while sequencing is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (!enable) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_MAX) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Next pattern for the selected mode; illegal walking-one values restart at bit 0.
    always_comb begin
        w_next_pattern = 10'h000;
        case (mode)
            2'b00: begin
                if ((r_pattern != 10'h000) && ((r_pattern & (r_pattern - 10'd1)) == 10'h000))
                    w_next_pattern = {r_pattern[8:0], r_pattern[9]};
                else
                    w_next_pattern = 10'h001;
            end
            2'b01:   w_next_pattern = r_pattern + 10'd1;
            2'b10:   w_next_pattern = (r_pattern == 10'h155) ? 10'h2AA : 10'h155;
            default: w_next_pattern = (r_pattern == 10'h000) ? 10'h3FF : 10'h000;
        endcase
    end

    // Readback compare and saturating increment; a coincident clear resets the base so the mismatch lands as 1.
    always_comb begin
        w_mismatch = (r_rdata[9:0] != r_pattern) || (r_rdata[31:10] != 22'h0);
        w_cnt_base = clear_error ? 8'h00 : r_cnt;
        w_cnt_inc  = (w_cnt_base == 8'hFF) ? 8'hFF : (w_cnt_base + 8'h01);
    end

    // Transaction FSM: one write then one readback per accepted tick, all bus strobes registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pattern <= 10'h000;
            r_cs      <= 1'b0;
            r_we      <= 1'b0;
            r_rd      <= 1'b0;
            r_wdata   <= 32'h0;
            r_lat     <= 3'd0;
            r_rdata   <= 32'h0;
            r_error   <= 1'b0;
            r_cnt     <= 8'h00;
        end else begin
            if (clear_error) begin
                r_error <= 1'b0;
                r_cnt   <= 8'h00;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_pattern <= w_next_pattern;
                        r_wdata   <= {22'h0, w_next_pattern};
                        r_cs      <= 1'b1;
                        r_we      <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!avm_waitrequest) begin
                        r_we    <= 1'b0;
                        r_rd    <= 1'b1;
                        r_wdata <= 32'h0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (!avm_waitrequest) begin
                        r_rd    <= 1'b0;
                        r_cs    <= 1'b0;
                        r_lat   <= 3'd0;
                        r_state <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (r_lat == LAT_MAX) begin
                        r_rdata <= avm_readdata;
                        r_state <= S_CHECK;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_error <= 1'b1;
                        r_cnt   <= w_cnt_inc;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = r_cs;
    assign avm_write      = r_we;
    assign avm_read       = r_rd;
    assign avm_writedata  = r_wdata;
    assign pattern        = r_pattern;
    assign busy           = (r_state != S_IDLE);
    assign error          = r_error;
    assign mismatch_count = r_cnt;

endmodule

// File: tb/tb_led_pattern_master.sv
// tb/tb_led_pattern_master.sv - directed self-checking bench for led_pattern_master
module tb_led_pattern_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic        clear_error;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [9:0]  pattern;
    logic        busy;
    logic        error;
    logic [7:0]  mismatch_count;

    logic [31:0] mem = 32'h0;
    logic        corrupt;
    logic [9:0]  wq[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    led_pattern_master #(.TICK_DIV(4), .READ_LATENCY(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .mode            (mode),
        .clear_error     (clear_error),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .pattern         (pattern),
        .busy            (busy),
        .error           (error),
        .mismatch_count  (mismatch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (avm_chipselect && avm_write && !avm_waitrequest)
            mem <= avm_writedata;

    assign avm_readdata = corrupt ? (mem | 32'h0000_0400) : mem;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) chk_eq("idle_timeout", busy, 0);
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        int cyc  = 0;
        enable = 1'b1;
        while (seen < n && cyc < n * 40 + 100) begin
            @(negedge clk);
            cyc++;
            if (avm_chipselect && avm_write && !avm_waitrequest) begin
                wq.push_back(avm_writedata[9:0]);
                seen++;
                if (seen == n) enable = 1'b0;
            end
        end
        enable = 1'b0;
        if (seen < n) chk_eq("tick_timeout", seen, n);
        wait_idle();
    endtask

    initial begin
        int base;
        int found;
        reset_n = 1'b0; enable = 1'b0; mode = 2'b00; clear_error = 1'b0;
        avm_waitrequest = 1'b0; corrupt = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_pattern", pattern, 10'h000);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_strobes", {avm_chipselect, avm_write, avm_read}, 3'b000);
        chk_eq("rst_wdata", avm_writedata, 0);
        chk_eq("rst_addr", avm_address, 0);
        chk_eq("rst_err", {error, mismatch_count}, 9'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // walking one from 0: 001..200 then wrap to 001
        mode = 2'b00;
        run_ticks(11);
        for (int i = 0; i < 11; i++)
            chk_eq($sformatf("walk%0d", i), wq[i], (i < 10) ? (32'h1 << i) : 32'h1);
        chk_eq("walk_err", {error, mismatch_count}, 9'h0);
        chk_eq("walk_pat", pattern, 10'h001);

        // all-off/all-on to reach 3FF, then binary count wraps to 000
        base = wq.size();
        mode = 2'b11;
        run_ticks(2);
        chk_eq("onoff0", wq[base], 10'h000);
        chk_eq("onoff1", wq[base + 1], 10'h3FF);
        mode = 2'b01;
        run_ticks(1);
        chk_eq("cnt_wrap", wq[base + 2], 10'h000);
        chk_eq("cnt_wrap_err", {error, mismatch_count}, 9'h0);

        // write stalled 3 cycles by waitrequest
        avm_waitrequest = 1'b1;
        enable = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (avm_write) found = 1;
        end
        enable = 1'b0;
        if (found == 0) chk_eq("stall_timeout", found, 1);
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("stall_we%0d", i), {avm_chipselect, avm_write, avm_read}, 3'b110);
            chk_eq($sformatf("stall_wd%0d", i), avm_writedata, 32'h001);
            if (i == 3) avm_waitrequest = 1'b0;
            @(negedge clk);
        end
        chk_eq("stall_read", {avm_chipselect, avm_write, avm_read}, 3'b101);
        wait_idle();
        chk_eq("stall_err", error, 0);

        // corrupted readback of pattern 000 -> 400
        mode = 2'b11;
        corrupt = 1'b1;
        run_ticks(1);
        chk_eq("mm_pat", pattern, 10'h000);
        chk_eq("mm_err", error, 1);
        chk_eq("mm_cnt", mismatch_count, 1);
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        chk_eq("clr_err", {error, mismatch_count}, 9'h0);

        // clear_error coincident with CHECK mismatch: mismatch wins, count restarts at 1
        run_ticks(1);
        chk_eq("pre_cnt", mismatch_count, 1);
        enable = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (avm_read && !avm_waitrequest) found = 1;
        end
        enable = 1'b0;
        if (found == 0) chk_eq("rd_timeout", found, 1);
        repeat (3) @(negedge clk);
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        wait_idle();
        chk_eq("coinc_err", error, 1);
        chk_eq("coinc_cnt", mismatch_count, 1);

        // saturation after 300 more mismatches
        mode = 2'b01;
        run_ticks(300);
        chk_eq("sat_cnt", mismatch_count, 8'hFF);
        chk_eq("sat_err", error, 1);
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        chk_eq("sat_clr", {error, mismatch_count}, 9'h0);

        // asynchronous reset during READ
        corrupt = 1'b0;
        enable = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (avm_read) found = 1;
        end
        if (found == 0) chk_eq("rst_rd_timeout", found, 1);
        enable = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_eq("arst_strobes", {avm_chipselect, avm_write, avm_read}, 3'b000);
        chk_eq("arst_wdata", avm_writedata, 0);
        chk_eq("arst_pat", pattern, 10'h000);
        chk_eq("arst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // first tick exactly TICK_DIV cycles after enable sampled high
        mode = 2'b00;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) chk_eq($sformatf("first_tick_early%0d", k), avm_write, 0);
            else begin
                chk_eq("first_tick_we", avm_write, 1);
                chk_eq("first_tick_wd", avm_writedata, 32'h001);
            end
        end
        enable = 1'b0;
        wait_idle();
        chk_eq("final_err", error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
